// File: rtl/uart_defs_pkg.sv
// -----------------------------------------------------------------------------
// uart_defs
// Shared UART definitions used by the receiver and the matching transmitter:
// default baud divider, FSM state encoding and the 16x-oversample positions.
// -----------------------------------------------------------------------------
package uart_defs;

    // sysclk cycles per 16x-oversample tick: 50 MHz / 9600 baud / 16
    localparam int unsigned BAUD_DIV_DEFAULT = 325;

    // Oversample positions within one bit period (16 ticks per bit)
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    // Index of the last data bit (8 data bits, LSB first)
    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_BRKWAIT = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running 16x-oversample tick generator. Counts 0..BAUD_DIV-1 and wraps;
// tick is high for the one cycle in which the count equals BAUD_DIV-1.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset (count returns to 0)
//   tick  - one-cycle oversample strobe
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_defs::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the top value, otherwise increment
    always_comb begin
        if (cnt_q == TOP) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TOP);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling, framing-error and overrun flags,
// and break handling (a continuous low line yields a single 0x00 frame).
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   rs232_rx   - asynchronous serial input, idle high
//   rx_ack     - one-cycle pulse when the bus reads the receive buffer
//   rx_data    - last received character
//   rx_done    - a character is available
//   rx_ferr    - framing error on the last character
//   rx_overrun - a character was overwritten before it was acknowledged
//   rx_busy    - receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_defs::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs232_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_ferr,
    output logic       rx_overrun,
    output logic       rx_busy
);

    logic        tick_s;
    logic        line_s;
    logic        load_s;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    uart_state_e state_q, state_d;
    logic [3:0]  sample_q, sample_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_done_q, rx_done_d;
    logic        rx_ferr_q, rx_ferr_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        rx_busy_q, rx_busy_d;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Two-flop synchronizer feeding all line decisions
    always_comb begin
        sync1_d = rs232_rx;
        sync2_d = sync1_q;
    end

    assign line_s = sync2_q;

    // FSM next state; every transition is gated by the oversample tick
    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        load_s    = 1'b0;
        if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!line_s) begin
                        state_d  = ST_START;
                        sample_d = 4'd0;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (sample_q == MID_SAMPLE) begin
                        // A start bit that is no longer low at mid-bit is a glitch
                        if (line_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                        sample_d  = 4'd0;
                        bit_idx_d = 3'd0;
                    end else begin
                        sample_d  = sample_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (sample_q == LAST_SAMPLE) begin
                        // Counting from mid-start, sample 15 lands mid-bit
                        shift_d  = {line_s, shift_q[7:1]};
                        sample_d = 4'd0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d   = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (sample_q == LAST_SAMPLE) begin
                        load_s   = 1'b1;
                        sample_d = 4'd0;
                        // A low stop bit may be a break: wait for the line to recover
                        if (line_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BRKWAIT;
                        end
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
                ST_BRKWAIT: begin
                    if (line_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BRKWAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receive buffer and status flags; a frame load takes priority over rx_ack
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_done_d    = rx_done_q;
        rx_ferr_d    = rx_ferr_q;
        rx_overrun_d = rx_overrun_q;
        if (load_s) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
            rx_ferr_d = ~line_s;
            if (rx_done_q && !rx_ack) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_overrun_d = rx_overrun_q;
            end
        end else if (rx_ack && rx_done_q) begin
            rx_done_d    = 1'b0;
            rx_overrun_d = 1'b0;
        end else begin
            rx_done_d    = rx_done_q;
        end
        rx_busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= ST_IDLE;
            sample_q     <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_done_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            sample_q     <= sample_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_overrun_q <= rx_overrun_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign rx_ferr    = rx_ferr_q;
    assign rx_overrun = rx_overrun_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with BAUD_DIV=4 (64 clk per bit). Frames are
// launched on a known divider phase so the load cycle is a fixed offset
// (610 clk) from the start-bit edge: the start bit reaches the FSM on a tick,
// then 32 clk to mid-start, 9 x 64 clk to mid-stop, +2 for sync/phase.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rs232_rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_ferr;
    logic       rx_overrun;
    logic       rx_busy;

    int   checks   = 0;
    int   failures = 0;
    int   pcnt     = 0;
    int   rises    = 0;
    logic prev_done;
    logic d610;
    logic d611;

    uart_rx #(
        .BAUD_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs232_rx   (rs232_rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_ferr    (rx_ferr),
        .rx_overrun (rx_overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
        pcnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line level for bit slot idx of an 8N1 frame (0=start, 1..8 data, 9 stop)
    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    // Wait for the divider phase where a start edge reaches the FSM on a tick
    task automatic align();
        while ((pcnt % 4) != 1) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_load);
        align();
        for (int t = 0; t < 640; t++) begin
            rs232_rx = fbit(b, t / 64);
            rx_ack   = ack_load && (t == 610);
            step();
            if (t + 1 == 610) d610 = rx_done;
            if (t + 1 == 611) d611 = rx_done;
        end
        rs232_rx = 1'b1;
        rx_ack   = 1'b0;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rs232_rx = 1'b1;
        rx_ack   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        pcnt  = 0;
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_done", {31'd0, rx_done}, 32'd0);
        chk("rst_ferr", {31'd0, rx_ferr}, 32'd0);
        chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        repeat (20) step();
        chk("idle_busy", {31'd0, rx_busy}, 32'd0);

        // 0x55 clean frame, exact load latency, then ack
        send_byte(8'h55, 1'b0);
        chk("lat_before", {31'd0, d610}, 32'd0);
        chk("lat_after", {31'd0, d611}, 32'd1);
        chk("x55_data", {24'd0, rx_data}, 32'h55);
        chk("x55_done", {31'd0, rx_done}, 32'd1);
        chk("x55_ferr", {31'd0, rx_ferr}, 32'd0);
        chk("x55_ovr", {31'd0, rx_overrun}, 32'd0);
        do_ack();
        chk("ack_done", {31'd0, rx_done}, 32'd0);
        do_ack();
        chk("ack_idle_done", {31'd0, rx_done}, 32'd0);
        chk("ack_idle_data", {24'd0, rx_data}, 32'h55);

        // 20-clk glitch on an idle line
        align();
        rs232_rx = 1'b0;
        repeat (10) step();
        chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
        repeat (10) step();
        rs232_rx = 1'b1;
        repeat (60) step();
        chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
        chk("glitch_done", {31'd0, rx_done}, 32'd0);
        chk("glitch_data", {24'd0, rx_data}, 32'h55);

        // Overrun: two frames with no ack
        send_byte(8'hA3, 1'b0);
        chk("a3_ovr", {31'd0, rx_overrun}, 32'd0);
        send_byte(8'h3C, 1'b0);
        chk("ovr_data", {24'd0, rx_data}, 32'h3C);
        chk("ovr_done", {31'd0, rx_done}, 32'd1);
        chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        do_ack();
        chk("ovr_ack_done", {31'd0, rx_done}, 32'd0);
        chk("ovr_ack_flag", {31'd0, rx_overrun}, 32'd0);

        // Break: 2000 clk low yields one 0x00 frame with framing error
        align();
        rs232_rx  = 1'b0;
        rises     = 0;
        prev_done = rx_done;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (rx_done && !prev_done) rises++;
            prev_done = rx_done;
        end
        chk("brk_frames", rises, 32'd1);
        chk("brk_data", {24'd0, rx_data}, 32'h00);
        chk("brk_ferr", {31'd0, rx_ferr}, 32'd1);
        chk("brk_busy", {31'd0, rx_busy}, 32'd1);
        chk("brk_ovr", {31'd0, rx_overrun}, 32'd0);
        rs232_rx = 1'b1;
        repeat (10) step();
        chk("brk_release", {31'd0, rx_busy}, 32'd0);
        do_ack();
        chk("brk_ack_ferr", {31'd0, rx_ferr}, 32'd1);
        send_byte(8'h41, 1'b0);
        chk("x41_data", {24'd0, rx_data}, 32'h41);
        chk("x41_ferr", {31'd0, rx_ferr}, 32'd0);

        // 0x7E with ack in the load cycle while a character is pending
        send_byte(8'h7E, 1'b1);
        chk("same_done", {31'd0, rx_done}, 32'd1);
        chk("same_data", {24'd0, rx_data}, 32'h7E);
        chk("same_ovr", {31'd0, rx_overrun}, 32'd0);

        // Reset during data bit 4 of 0xFF
        align();
        for (int t = 0; t < 352; t++) begin
            rs232_rx = fbit(8'hFF, t / 64);
            step();
        end
        chk("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, rx_data}, 32'h00);
        chk("mid_rst_done", {31'd0, rx_done}, 32'd0);
        chk("mid_rst_ferr", {31'd0, rx_ferr}, 32'd0);
        chk("mid_rst_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        rs232_rx = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        pcnt  = 0;
        repeat (10) step();
        chk("post_rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("post_rst_done", {31'd0, rx_done}, 32'd0);
        send_byte(8'h12, 1'b0);
        chk("x12_data", {24'd0, rx_data}, 32'h12);
        chk("x12_done", {31'd0, rx_done}, 32'd1);
        chk("x12_ferr", {31'd0, rx_ferr}, 32'd0);
        chk("x12_ovr", {31'd0, rx_overrun}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
